// File: rtl/snoop_cache_ctrl.sv
// Two-line direct-mapped MSI cache controller on the snooping bus.
// It turns CPU requests into bus messages and answers snooped readMiss and invalidate messages.
//
// state | meaning
// IDLE  | accept a snoop (has priority) or a CPU request
// WB    | write the dirty victim back, then fetch
// MISS  | drive readMiss for the latched address
// FILL  | capture the memory response into the line
// INV   | broadcast invalidate, line becomes M
// DONE  | completion pulse to the CPU
// SNWB  | supply a modified line to a snooping reader
module snoop_cache_ctrl (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [2:0] cpu_addr,
  input  logic [3:0] cpu_wdata,
  output logic       cpu_ready,
  output logic [3:0] cpu_rdata,
  output logic [8:0] busOut,
  output logic       bus_valid,
  input  logic [8:0] memOut,
  input  logic [8:0] snoop_in,
  input  logic       snoop_valid,
  output logic       snoop_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_WB, S_MISS, S_FILL, S_INV, S_DONE, S_SNWB
  } state_t;

  localparam logic [1:0] ST_I     = 2'd0;
  localparam logic [1:0] ST_S     = 2'd1;
  localparam logic [1:0] ST_M     = 2'd2;
  localparam logic [1:0] MSG_RM   = 2'd0;
  localparam logic [1:0] MSG_WB   = 2'd1;
  localparam logic [1:0] MSG_INV  = 2'd2;
  localparam logic [8:0] BUS_IDLE = 9'h180;

  state_t r_state, w_next;

  logic [2:0] r_tag  [2];
  logic [3:0] r_data [2];
  logic [1:0] r_st   [2];

  logic       r_we;
  logic [2:0] r_addr;
  logic [3:0] r_wdata;
  logic       r_sidx;

  logic [8:0] r_bus;
  logic       r_bus_valid;
  logic       r_ready;
  logic [3:0] r_rdata;

  logic       w_cidx, w_chit;
  logic       w_sidx, w_shit;
  logic [2:0] w_stag;
  logic       w_line_idx;
  logic [2:0] w_cur_tag;
  logic [3:0] w_cur_data;
  logic [1:0] w_cur_st;

  logic       w_line_we;
  logic [2:0] w_line_tag;
  logic [3:0] w_line_data;
  logic [1:0] w_line_st;
  logic [8:0] w_msg;
  logic       w_msg_vld;
  logic       w_accept;
  logic       w_snoop_take;
  logic       w_done;
  logic       w_unused;

  assign w_unused = ^{memOut[8:4], snoop_in[3:0]};

  assign w_cidx = cpu_addr[0];
  assign w_chit = (r_st[w_cidx] != ST_I) && (r_tag[w_cidx] == cpu_addr);
  assign w_stag = snoop_in[6:4];
  assign w_sidx = w_stag[0];
  assign w_shit = (r_st[w_sidx] != ST_I) && (r_tag[w_sidx] == w_stag);

  // Only one line is touched per cycle; pick it from the current activity.
  always_comb begin
    w_line_idx = r_addr[0];
    if (r_state == S_IDLE)
      w_line_idx = snoop_valid ? w_sidx : w_cidx;
    else if (r_state == S_SNWB)
      w_line_idx = r_sidx;
  end

  assign w_cur_tag  = r_tag[w_line_idx];
  assign w_cur_data = r_data[w_line_idx];
  assign w_cur_st   = r_st[w_line_idx];

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_line_we    = 1'b0;
    w_line_tag   = w_cur_tag;
    w_line_data  = w_cur_data;
    w_line_st    = w_cur_st;
    w_msg        = BUS_IDLE;
    w_msg_vld    = 1'b0;
    w_accept     = 1'b0;
    w_snoop_take = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (snoop_valid) begin
          w_snoop_take = 1'b1;
          if (w_shit) begin
            case (snoop_in[8:7])
              MSG_RM: if (w_cur_st == ST_M) w_next = S_SNWB;
              MSG_INV: begin
                w_line_we = 1'b1;
                w_line_st = ST_I;
              end
              default: ;
            endcase
          end
        end else if (cpu_req) begin
          w_accept = 1'b1;
          if (w_chit && !cpu_we) begin
            w_next = S_DONE;
          end else if (w_chit && (w_cur_st == ST_M)) begin
            w_line_we   = 1'b1;
            w_line_data = cpu_wdata;
            w_next      = S_DONE;
          end else if (w_chit) begin
            w_next = S_INV;
          end else if (w_cur_st == ST_M) begin
            w_next = S_WB;
          end else begin
            w_next = S_MISS;
          end
        end
      end
      S_SNWB: begin
        w_msg     = {MSG_WB, w_cur_tag, w_cur_data};
        w_msg_vld = 1'b1;
        w_line_we = 1'b1;
        w_line_st = ST_S;
        w_next    = S_IDLE;
      end
      S_WB: begin
        w_msg     = {MSG_WB, w_cur_tag, w_cur_data};
        w_msg_vld = 1'b1;
        w_line_we = 1'b1;
        w_line_st = ST_I;
        w_next    = S_MISS;
      end
      S_MISS: begin
        w_msg     = {MSG_RM, r_addr, 4'h0};
        w_msg_vld = 1'b1;
        w_next    = S_FILL;
      end
      S_FILL: begin
        w_line_we   = 1'b1;
        w_line_tag  = r_addr;
        w_line_data = r_we ? r_wdata : memOut[3:0];
        w_line_st   = r_we ? ST_M : ST_S;
        w_next      = r_we ? S_INV : S_DONE;
      end
      S_INV: begin
        // Idempotent after a write fill; this is where a write hit on S lands its data.
        w_msg       = {MSG_INV, r_addr, 4'h0};
        w_msg_vld   = 1'b1;
        w_line_we   = 1'b1;
        w_line_tag  = r_addr;
        w_line_data = r_wdata;
        w_line_st   = ST_M;
        w_next      = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        r_tag[i]  <= 3'd0;
        r_data[i] <= 4'd0;
        r_st[i]   <= ST_I;
      end
      r_we        <= 1'b0;
      r_addr      <= 3'd0;
      r_wdata     <= 4'd0;
      r_sidx      <= 1'b0;
      r_bus       <= BUS_IDLE;
      r_bus_valid <= 1'b0;
      r_ready     <= 1'b0;
      r_rdata     <= 4'd0;
    end else begin
      if (w_line_we) begin
        r_tag[w_line_idx]  <= w_line_tag;
        r_data[w_line_idx] <= w_line_data;
        r_st[w_line_idx]   <= w_line_st;
      end
      if (w_accept) begin
        r_we    <= cpu_we;
        r_addr  <= cpu_addr;
        r_wdata <= cpu_wdata;
      end
      if (w_snoop_take) r_sidx <= w_sidx;
      r_bus       <= w_msg;
      r_bus_valid <= w_msg_vld;
      r_ready     <= w_done;
      if (w_done) r_rdata <= w_cur_data;
    end
  end

  assign busOut      = r_bus;
  assign bus_valid   = r_bus_valid;
  assign cpu_ready   = r_ready;
  assign cpu_rdata   = r_rdata;
  assign snoop_ready = (r_state == S_IDLE);

endmodule

// File: tb/tb_snoop_cache_ctrl.sv
// Bench for snoop_cache_ctrl: scripted scenarios plus random CPU/snoop traffic,
// checked against an abstract cache/memory model with spec-level latencies.
module tb_snoop_cache_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_req = 1'b0;
  logic       cpu_we = 1'b0;
  logic [2:0] cpu_addr = 3'd0;
  logic [3:0] cpu_wdata = 4'd0;
  logic       cpu_ready;
  logic [3:0] cpu_rdata;
  logic [8:0] busOut;
  logic       bus_valid;
  logic [8:0] memOut = 9'd0;
  logic [8:0] snoop_in = 9'h180;
  logic       snoop_valid = 1'b0;
  logic       snoop_ready;

  int errors = 0;
  int checks = 0;

  logic [2:0] m_tag  [2];
  logic [3:0] m_data [2];
  int         m_st   [2];
  logic [3:0] mem_m  [8];
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  logic [3:0] last_rd;

  always #5 clock = ~clock;

  snoop_cache_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .busOut(busOut), .bus_valid(bus_valid), .memOut(memOut),
    .snoop_in(snoop_in), .snoop_valid(snoop_valid), .snoop_ready(snoop_ready)
  );

  // Memory responder: valid fill data only while a readMiss is on the bus, noise otherwise.
  always @(posedge clock) begin
    #2;
    if (bus_valid && busOut[8:7] == 2'b00) memOut = {5'd0, mem_m[busOut[6:4]]};
    else memOut = 9'($urandom);
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_tag[i] = 3'd0; m_data[i] = 4'd0; m_st[i] = 0;
    end
  endtask

  task automatic model_snoop(input logic [8:0] sn, output bit snwb);
    logic [2:0] t;
    int idx;
    bit hit;
    t = sn[6:4];
    idx = int'(t[0]);
    hit = (m_st[idx] != 0) && (m_tag[idx] == t);
    snwb = 0;
    if (sn[8:7] == 2'd0 && hit && m_st[idx] == 2) begin
      exp_q.push_back({2'b01, t, m_data[idx]});
      mem_m[t] = m_data[idx];
      m_st[idx] = 1;
      snwb = 1;
    end else if (sn[8:7] == 2'd2 && hit) begin
      m_st[idx] = 0;
    end
  endtask

  task automatic model_cpu(input logic we, input logic [2:0] addr, input logic [3:0] wd,
                           output int lat, output logic [3:0] rd);
    int idx;
    bit hit;
    idx = int'(addr[0]);
    hit = (m_st[idx] != 0) && (m_tag[idx] == addr);
    if (hit && !we) begin
      lat = 1;
    end else if (hit && m_st[idx] == 2) begin
      lat = 1; m_data[idx] = wd;
    end else if (hit) begin
      exp_q.push_back({2'b10, addr, 4'h0});
      lat = 2; m_data[idx] = wd; m_st[idx] = 2;
    end else begin
      lat = we ? 4 : 3;
      if (m_st[idx] == 2) begin
        exp_q.push_back({2'b01, m_tag[idx], m_data[idx]});
        mem_m[m_tag[idx]] = m_data[idx];
        lat++;
      end
      exp_q.push_back({2'b00, addr, 4'h0});
      if (we) exp_q.push_back({2'b10, addr, 4'h0});
      m_tag[idx] = addr;
      m_data[idx] = we ? wd : mem_m[addr];
      m_st[idx] = we ? 2 : 1;
    end
    rd = m_data[idx];
  endtask

  // mode 0: plain request; 1: snoop raised with the request; 2: snoop raised while busy.
  task automatic do_cpu(input logic we, input logic [2:0] addr, input logic [3:0] wd,
                        input int mode, input logic [8:0] sn, input int tail, input string name);
    int lat, exp_cyc, cyc, acc;
    bit got, snwb, idle_bad, extra;
    logic [3:0] exp_rd;
    bit bad;
    exp_q = {}; obs_q = {};
    snwb = 0; got = 0; idle_bad = 0; extra = 0;
    if (mode == 1) model_snoop(sn, snwb);
    model_cpu(we, addr, wd, lat, exp_rd);
    acc = (mode == 1) ? (snwb ? 3 : 2) : 1;
    exp_cyc = lat + acc;
    if (mode == 2) model_snoop(sn, snwb);
    cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    if (mode == 1) begin
      snoop_in = sn; snoop_valid = 1;
      checks++;
      if (snoop_ready !== 1'b1) begin
        errors++; $display("FAIL %s snoop_ready_idle: got %b want 1", name, snoop_ready);
      end
    end
    cyc = 0;
    while (!got && cyc < 16) begin
      @(posedge clock); #1;
      cyc++;
      if (mode == 1 && cyc == 1) snoop_valid = 0;
      if (cyc >= acc) begin
        cpu_we = 1'($urandom); cpu_addr = 3'($urandom_range(0, 6)); cpu_wdata = 4'($urandom);
      end
      if (mode == 2 && cyc == 1) begin
        checks++;
        if (snoop_ready !== 1'b0) begin
          errors++; $display("FAIL %s snoop_ready_busy: got %b want 0", name, snoop_ready);
        end
        snoop_in = sn; snoop_valid = 1;
      end
      if (bus_valid) obs_q.push_back(busOut);
      else if (busOut !== 9'h180) idle_bad = 1;
      if (cpu_ready) begin
        got = 1; last_rd = cpu_rdata; cpu_req = 0;
      end
    end
    if (mode == 2 && got) begin
      checks++;
      if (snoop_ready !== 1'b1) begin
        errors++; $display("FAIL %s snoop_ready_after: got %b want 1", name, snoop_ready);
      end
    end
    for (int t = 0; t < tail; t++) begin
      @(posedge clock); #1;
      if (mode == 2 && t == 0) snoop_valid = 0;
      if (bus_valid) obs_q.push_back(busOut);
      else if (busOut !== 9'h180) idle_bad = 1;
      if (cpu_ready) extra = 1;
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL %s latency: no cpu_ready within %0d cycles, want %0d", name, cyc, exp_cyc);
    end else if (cyc !== exp_cyc) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_cyc);
    end
    checks++;
    if (got && last_rd !== exp_rd) begin
      errors++; $display("FAIL %s rdata: got %h want %h", name, last_rd, exp_rd);
    end
    bad = (obs_q.size() != exp_q.size());
    if (!bad) foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) bad = 1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s bus_msgs: got %0d msgs first %h, want %0d msgs first %h", name,
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 9'h0,
               exp_q.size(), (exp_q.size() > 0) ? exp_q[0] : 9'h0);
    end
    checks++;
    if (idle_bad !== 1'b0) begin
      errors++; $display("FAIL %s idle_code: got non-180 idle bus want 180", name);
    end
    checks++;
    if (extra !== 1'b0) begin
      errors++; $display("FAIL %s extra_ready: got extra pulse want none", name);
    end
  endtask

  task automatic do_snoop(input logic [8:0] sn, input string name);
    bit snwb, bad;
    exp_q = {}; obs_q = {};
    model_snoop(sn, snwb);
    checks++;
    if (snoop_ready !== 1'b1) begin
      errors++; $display("FAIL %s snoop_ready: got %b want 1", name, snoop_ready);
    end
    snoop_in = sn; snoop_valid = 1;
    @(posedge clock); #1;
    snoop_valid = 0;
    if (bus_valid) obs_q.push_back(busOut);
    for (int t = 0; t < 2; t++) begin
      @(posedge clock); #1;
      if (bus_valid) obs_q.push_back(busOut);
    end
    bad = (obs_q.size() != exp_q.size());
    if (!bad) foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) bad = 1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s snoop_msgs: got %0d msgs first %h, want %0d msgs first %h", name,
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 9'h0,
               exp_q.size(), (exp_q.size() > 0) ? exp_q[0] : 9'h0);
    end
  endtask

  task automatic test_reset();
    reset_n = 0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (busOut !== 9'h180) begin errors++; $display("FAIL reset busOut: got %h want 180", busOut); end
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL reset bus_valid: got %b want 0", bus_valid); end
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL reset cpu_ready: got %b want 0", cpu_ready); end
    checks++; if (cpu_rdata !== 4'h0) begin errors++; $display("FAIL reset cpu_rdata: got %h want 0", cpu_rdata); end
    checks++; if (snoop_ready !== 1'b1) begin errors++; $display("FAIL reset snoop_ready: got %b want 1", snoop_ready); end
    reset_n = 1;
    model_reset();
    for (int i = 0; i < 8; i++) mem_m[i] = 4'($urandom);
  endtask

  task automatic test_read_miss();
    mem_m[3] = 4'hA;
    do_cpu(0, 3'd3, 4'h0, 0, 9'h180, 3, "read_miss");
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 9'h030) begin
      errors++; $display("FAIL read_miss bus: got %0d msgs want one 030", obs_q.size());
    end
    checks++; if (last_rd !== 4'hA) begin errors++; $display("FAIL read_miss data: got %h want A", last_rd); end
  endtask

  task automatic test_write_hit_s();
    do_cpu(1, 3'd3, 4'h5, 0, 9'h180, 3, "write_hit_s");
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 9'h130) begin
      errors++; $display("FAIL write_hit_s bus: got %0d msgs want one 130", obs_q.size());
    end
  endtask

  task automatic test_dirty_evict();
    mem_m[1] = 4'h7;
    do_cpu(0, 3'd1, 4'h0, 0, 9'h180, 3, "dirty_evict");
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== 9'h0B5 || obs_q[1] !== 9'h010) begin
      errors++; $display("FAIL dirty_evict bus: got %0d msgs want 0B5,010", obs_q.size());
    end
    checks++; if (last_rd !== 4'h7) begin errors++; $display("FAIL dirty_evict data: got %h want 7", last_rd); end
  endtask

  task automatic test_snoop_priority();
    do_cpu(1, 3'd3, 4'h5, 0, 9'h180, 3, "prio_setup");
    do_cpu(0, 3'd1, 4'h0, 1, 9'h030, 3, "snoop_prio");
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== 9'h0B5 || obs_q[1] !== 9'h010) begin
      errors++; $display("FAIL snoop_prio bus: got %0d msgs want 0B5,010", obs_q.size());
    end
  endtask

  task automatic test_snoop_invalidate();
    do_cpu(0, 3'd2, 4'h0, 0, 9'h180, 3, "inv_setup");
    do_snoop(9'h120, "snoop_inv");
    checks++;
    if (obs_q.size() !== 0) begin errors++; $display("FAIL snoop_inv quiet: got %0d msgs want 0", obs_q.size()); end
    do_cpu(0, 3'd2, 4'h0, 0, 9'h180, 3, "inv_reread");
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 9'h020) begin
      errors++; $display("FAIL inv_reread bus: got %0d msgs want one 020", obs_q.size());
    end
  endtask

  task automatic test_snoop_wait();
    do_cpu(0, 3'd4, 4'h0, 2, 9'h140, 3, "snoop_wait");
    do_cpu(0, 3'd4, 4'h0, 0, 9'h180, 3, "wait_reread");
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 9'h040) begin
      errors++; $display("FAIL wait_reread bus: got %0d msgs want one 040", obs_q.size());
    end
  endtask

  task automatic test_back_to_back();
    do_cpu(0, 3'd6, 4'h0, 0, 9'h180, 0, "b2b_miss");
    do_cpu(0, 3'd6, 4'h0, 0, 9'h180, 0, "b2b_hit");
    do_cpu(1, 3'd6, 4'h9, 0, 9'h180, 0, "b2b_wr_s");
    do_cpu(1, 3'd6, 4'hC, 0, 9'h180, 3, "b2b_wr_m");
    checks++; if (last_rd !== 4'hC) begin errors++; $display("FAIL b2b data: got %h want C", last_rd); end
  endtask

  task automatic test_reset_mid_miss();
    bit seen, extra;
    do_cpu(1, 3'd5, 4'h6, 0, 9'h180, 3, "rst_setup");
    cpu_req = 1; cpu_we = 0; cpu_addr = 3'd2; cpu_wdata = 4'h0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clock); #1;
      if (bus_valid && busOut[8:7] == 2'b00) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_mid wait_fill: got no readMiss want one"); end
    reset_n = 0;
    @(posedge clock); #1;
    checks++; if (busOut !== 9'h180) begin errors++; $display("FAIL rst_mid busOut: got %h want 180", busOut); end
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL rst_mid cpu_ready: got %b want 0", cpu_ready); end
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL rst_mid bus_valid: got %b want 0", bus_valid); end
    cpu_req = 0; reset_n = 1;
    model_reset();
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      if (cpu_ready) extra = 1;
    end
    checks++; if (extra !== 1'b0) begin errors++; $display("FAIL rst_mid stale_ready: got pulse want none"); end
    do_cpu(0, 3'd5, 4'h0, 0, 9'h180, 3, "rst_reread");
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 9'h050) begin
      errors++; $display("FAIL rst_reread bus: got %0d msgs want one 050", obs_q.size());
    end
  endtask

  task automatic test_random();
    logic [8:0] sn;
    int mode, tail;
    for (int n = 0; n < 120; n++) begin
      sn = {2'($urandom_range(0, 3)), 3'($urandom_range(0, 6)), 4'($urandom)};
      if ($urandom_range(0, 9) < 2) begin
        do_snoop(sn, "rand_snoop");
      end else begin
        mode = $urandom_range(0, 2);
        tail = (mode == 0 && $urandom_range(0, 1) == 1) ? 0 : 3;
        do_cpu(1'($urandom), 3'($urandom_range(0, 6)), 4'($urandom), mode, sn, tail, "rand_cpu");
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_write_hit_s();
    test_dirty_evict();
    test_snoop_priority();
    test_snoop_invalidate();
    test_snoop_wait();
    test_back_to_back();
    test_reset_mid_miss();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snoop_cache_ctrl.md
# snoop_cache_ctrl

Processor-side initiator for the snooping coherence bus: a 2-line direct-mapped MSI cache controller. It turns CPU reads and writes into readMiss, writeBack and invalidate bus messages, captures fill data returned by the memory responder, and reacts to other caches' bus traffic through a snoop port. It sits between one processor and the shared 9-bit bus, opposite the memory module.

## Interface
- No parameters. Bus message fields are fixed: [8:7] message code, [6:4] tag (block address 0-6), [3:0] data.
- `clock`  in  1  Single clock; all state updates on the rising edge.
- `reset_n`  in  1  Synchronous, active-low reset; sampled on the rising edge of `clock`.
- `cpu_req`  in  1  CPU request; held high until `cpu_ready` pulses.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  3  Block address 0-6. Index = `cpu_addr[0]`; the full 3-bit address is stored as the line tag.
- `cpu_wdata`  in  4  Write data.
- `cpu_ready`  out  1  One-cycle completion pulse.
- `cpu_rdata`  out  4  Read data; valid while `cpu_ready` is high, holds its value otherwise.
- `busOut`  out  9  Message driven onto the bus. Codes: 0 readMiss, 1 writeBack, 2 invalidate, 3 idle.
- `bus_valid`  out  1  High for exactly the one cycle in which `busOut` carries a message.
- `memOut`  in  9  Memory response; `memOut[3:0]` holds the fill data.
- `snoop_in`  in  9  Another cache's bus message.
- `snoop_valid`  in  1  `snoop_in` is valid; held until `snoop_ready` is sampled high.
- `snoop_ready`  out  1  High when the FSM is in IDLE, combinational from state.

## Operation
- Per line: 3-bit tag, 4-bit data, 2-bit MSI state (I=0, S=1, M=2).
- Hit: the line at the index is not I and its tag equals the address.
- FSM states: IDLE, WB, MISS, FILL, INV, DONE, SNWB.
- **IDLE**
  - `snoop_valid` has priority over `cpu_req`. A snoop is consumed in the cycle it is sampled.
  - Snoop readMiss, tag hits an M line: go to SNWB.
  - Snoop readMiss, tag hits an S line: no action.
  - Snoop invalidate, tag hits: line goes to I, stay in IDLE.
  - Snoop writeBack or idle code: ignored.
  - CPU request (no snoop pending): latch `cpu_we`, `cpu_addr` and `cpu_wdata`. Later changes to these inputs are ignored.
    - Read hit: go to DONE.
    - Write hit on M: update the data, go to DONE.
    - Write hit on S: go to INV.
    - Miss with an M victim: go to WB.
    - Miss otherwise: go to MISS.
- **SNWB:** drive writeBack {1, line tag, line data}. Line goes to S. Next state IDLE.
- **WB:** drive writeBack {1, victim tag, victim data}. Victim goes to I. Next state MISS.
- **MISS:** drive readMiss {0, addr, 0}. Next state FILL.
- **FILL:** line tag := addr and line data := `memOut[3:0]`.
  - Read: line goes to S, next state DONE.
  - Write: line data := `cpu_wdata`, line goes to M, next state INV.
- **INV:** drive invalidate {2, addr, 0}. On a write-hit-S path, write the data and set the line to M here. Next state DONE.
- **DONE:** `cpu_ready` = 1 and `cpu_rdata` = line data. Next state IDLE.
- When no message is being sent, `busOut` = 9'h180 (idle code). The idle code is never 0, so the memory never sees a false readMiss.

## Timing
- Reset (`reset_n` = 0 at an edge):
  - FSM goes to IDLE and all lines go to I with tag 0 and data 0.
  - `busOut` = 9'h180; `bus_valid`, `cpu_ready` and `cpu_rdata` = 0.
  - Reset in the middle of a transaction aborts it with no completion pulse.
- All outputs are registered, except `snoop_ready`.
- Latency, counted from the request-accept edge to the edge where `cpu_ready` is high:
  - Read hit and write hit M: 1 cycle.
  - Write hit S: 2 cycles.
  - Read miss with a clean victim: 3 cycles; add 1 when the victim is dirty.
  - Write miss: 4 cycles; add 1 when the victim is dirty.
- `memOut` is sampled in FILL, one cycle after readMiss was driven.
- `cpu_req` and `snoop_valid` in the same IDLE cycle: the snoop wins. The CPU request is accepted on the next IDLE cycle.
- A snoop that arrives while the FSM is busy waits; `snoop_ready` stays low until IDLE.
- Back-to-back: a new request can be accepted in the IDLE cycle that follows DONE.

## Test plan
- **Read miss after reset:** read addr 3, `memOut[3:0]` = 4'hA in FILL.
  - Bus shows 0x030 with `bus_valid` for one cycle.
  - `cpu_ready` pulses with `cpu_rdata` = A, 3 cycles after accept.
  - Line 1 ends tag 3, state S.
- **Write hit on S:** after the read above, write addr 3 data 5.
  - Bus shows invalidate 0x130.
  - `cpu_ready` pulses 2 cycles after accept; line goes to M, data 5.
- **Dirty eviction:** line 1 is M with tag 3 and data 5; read addr 1 with memOut data 7.
  - Bus shows writeBack 0x0B5, then readMiss 0x010.
  - `cpu_rdata` = 7, 4 cycles after accept.
- **Snoop priority:** with line 1 M (tag 3, data 5), assert `snoop_in` = 0x030 and `cpu_req` (read addr 1) in the same cycle.
  - writeBack 0x0B5 is driven first and line 1 goes to S.
  - The CPU request is accepted in the following IDLE cycle.
- **Snoop invalidate:** line 0 is S with tag 2; `snoop_in` = 0x120.
  - Line 0 goes to I with no bus message.
  - A following read of addr 2 misses and issues readMiss 0x020.
- **Reset mid-miss:** drive `reset_n` = 0 in FILL.
  - Next cycle: `busOut` = 0x180, `cpu_ready` = 0, all lines I.
  - No stale completion pulse after reset releases.
